alu_ctrl_seq: RTL

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_pkg.sv | 75 +++++++
 rtl/md_iter_core.sv | 77 +++++++
 rtl/alu_ctrl_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_ctrl_pkg                                                     |
// | Brief   : ALU operation codes, control classes, M-extension encodings,    |
// |           FSM state encoding and the ALU operation decode function.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_ctrl_pkg;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0010;
    localparam logic [3:0] c_ALU_OR  = 4'b0011;
    localparam logic [3:0] c_ALU_XOR = 4'b0100;
    localparam logic [3:0] c_ALU_LUI = 4'b0101;
    localparam logic [3:0] c_ALU_SRL = 4'b0110;
    localparam logic [3:0] c_ALU_SLL = 4'b0111;

    localparam logic [2:0] c_ALUOP_R = 3'b000;
    localparam logic [2:0] c_ALUOP_I = 3'b001;
    localparam logic [2:0] c_ALUOP_U = 3'b100;

    localparam logic [2:0] c_F3_ADD = 3'b000;
    localparam logic [2:0] c_F3_SLL = 3'b001;
    localparam logic [2:0] c_F3_XOR = 3'b100;
    localparam logic [2:0] c_F3_SRL = 3'b101;
    localparam logic [2:0] c_F3_OR  = 3'b110;
    localparam logic [2:0] c_F3_AND = 3'b111;

    localparam logic [2:0] c_F3_MUL   = 3'b000;
    localparam logic [2:0] c_F3_MULHU = 3'b011;
    localparam logic [2:0] c_F3_DIVU  = 3'b101;
    localparam logic [2:0] c_F3_REMU  = 3'b111;

    localparam logic [6:0] c_F7_M = 7'b0000001;

    localparam int              c_ST_W    = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_RUN  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DONE = 2'd2;

    // f7b5 separates SUB from ADD and SRLI from SRAI; other uses fall to ADD.
    function automatic logic [3:0] f_alu_decode(input logic       f7b5,
                                                input logic [2:0] alu_op,
                                                input logic [2:0] f3);
        logic [3:0] res;
        res = c_ALU_ADD;
        case (alu_op)
            c_ALUOP_R: begin
                case (f3)
                    c_F3_ADD: res = f7b5 ? c_ALU_SUB : c_ALU_ADD;
                    c_F3_AND: res = f7b5 ? c_ALU_ADD : c_ALU_AND;
                    c_F3_OR:  res = f7b5 ? c_ALU_ADD : c_ALU_OR;
                    c_F3_XOR: res = f7b5 ? c_ALU_ADD : c_ALU_XOR;
                    default:  res = c_ALU_ADD;
                endcase
            end
            c_ALUOP_I: begin
                case (f3)
                    c_F3_ADD: res = c_ALU_ADD;
                    c_F3_AND: res = c_ALU_AND;
                    c_F3_OR:  res = c_ALU_OR;
                    c_F3_SRL: res = f7b5 ? c_ALU_ADD : c_ALU_SRL;
                    c_F3_SLL: res = f7b5 ? c_ALU_ADD : c_ALU_SLL;
                    default:  res = c_ALU_ADD;
                endcase
            end
            c_ALUOP_U: res = c_ALU_LUI;
            default:   res = c_ALU_ADD;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : md_iter_core                                                     |
// | Brief   : One-bit-per-cycle shift-add multiplier / restoring divider      |
// |           sharing one hi/lo register pair.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             is_div,
    input  logic             sel_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic               r_is_div;
    logic               r_sel_hi;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;

    // Multiply: hi accumulates, {hi,lo} shifts right, lo starts as multiplier.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH + 1){1'b0}});

    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_mcand});
    assign w_sub   = w_shift[WIDTH-1:0] - r_mcand;

    assign w_hi_next = r_is_div ? (w_ge ? w_sub : w_shift[WIDTH-1:0]) : w_add[WIDTH:1];
    assign w_lo_next = r_is_div ? {r_lo[WIDTH-2:0], w_ge} : {w_add[0], r_lo[WIDTH-1:1]};

    // Result is taken from the post-step values so it is ready on the last step.
    assign done   = run && (r_cnt == c_CNT_W'(1));
    assign result = r_sel_hi ? w_hi_next : w_lo_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_sel_hi <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_is_div <= is_div;
            r_sel_hi <= sel_hi;
            r_hi     <= '0;
            r_lo     <= a;
            r_mcand  <= b;
            r_cnt    <= c_CNT_W'(WIDTH);
        end else if (run && (r_cnt != '0)) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_ctrl_seq                                                     |
// | Brief   : ALU control decode plus sequencing of iterative multiply/divide.|
// |           Define ALU_CTRL_M_EXT_EN to build the M-extension datapath.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_ctrl_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [6:0]       funct7_i,
    input  logic [2:0]       ALU_Op_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic [3:0]       ALU_Operation_o,
    output logic             stall_o,
    output logic             md_valid_o,
    output logic [WIDTH-1:0] md_result_o,
    output logic             illegal_o
);

    import alu_ctrl_pkg::*;

    logic w_is_m;

    assign ALU_Operation_o = f_alu_decode(funct7_i[5], ALU_Op_i, funct3_i);
    assign w_is_m          = (ALU_Op_i == c_ALUOP_R) && (funct7_i == c_F7_M);

`ifdef ALU_CTRL_M_EXT_EN

    logic [c_ST_W-1:0] r_state;
    logic              r_md_valid;
    logic [WIDTH-1:0]  r_md_result;

    logic             w_m_ok;
    logic             w_idle;
    logic             w_accept;
    logic             w_div0;
    logic             w_start;
    logic             w_run;
    logic             w_core_done;
    logic [WIDTH-1:0] w_core_result;

    assign w_m_ok   = (funct3_i == c_F3_MUL)  || (funct3_i == c_F3_MULHU) ||
                      (funct3_i == c_F3_DIVU) || (funct3_i == c_F3_REMU);
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_accept = w_idle && valid_i && w_is_m && w_m_ok && !flush_i;
    assign w_div0   = funct3_i[2] && (b_i == '0);
    assign w_start  = w_accept && !w_div0;
    assign w_run    = (r_state == c_ST_RUN) && !flush_i;

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_md_iter_core (
        .clk    (clk),
        .reset  (reset),
        .start  (w_start),
        .run    (w_run),
        .is_div (funct3_i[2]),
        .sel_hi (funct3_i[1]),
        .a      (a_i),
        .b      (b_i),
        .done   (w_core_done),
        .result (w_core_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_md_valid  <= 1'b0;
            r_md_result <= '0;
        end else begin
            r_md_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_div0) begin
                            // DIVU by zero yields all ones, REMU yields the dividend.
                            r_state     <= c_ST_DONE;
                            r_md_valid  <= 1'b1;
                            r_md_result <= funct3_i[1] ? a_i : '1;
                        end else begin
                            r_state <= c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (flush_i) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_core_done) begin
                        r_state     <= c_ST_DONE;
                        r_md_valid  <= 1'b1;
                        r_md_result <= w_core_result;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign stall_o     = reset && (w_accept || (r_state == c_ST_RUN));
    assign md_valid_o  = r_md_valid;
    assign md_result_o = r_md_result;
    assign illegal_o   = reset && w_idle && valid_i && w_is_m && !w_m_ok;

`else

    logic w_unused;

    assign stall_o     = 1'b0;
    assign md_valid_o  = 1'b0;
    assign md_result_o = '0;
    assign illegal_o   = reset && valid_i && w_is_m;
    assign w_unused    = ^{clk, flush_i, a_i, b_i};

`endif

endmodule
`default_nettype wire
